// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes
// them to the instruction memory from address 0, holding the CPU in reset meanwhile.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
   // byte_ready depends on state only, byte_valid may be held or dropped freely.

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WR, S_FIN
   } state_t;

   localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

   state_t            state, state_next;
   logic              xfer;
   logic [7:0]        cnt_lo;
   logic [15:0]       hdr_n;
   logic              n_too_big;
   logic [15:0]       remaining;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        byte_idx;
   logic [23:0]       asm_word;

   assign xfer      = byte_valid && byte_ready;
   assign hdr_n     = {byte_data, cnt_lo};
   assign n_too_big = {16'd0, hdr_n} > DEPTH;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_HDR_LO;
         S_HDR_LO: if (xfer) state_next = S_HDR_HI;
         S_HDR_HI: if (xfer) state_next = (hdr_n == 16'd0 || n_too_big) ? S_FIN : S_DATA;
         S_DATA:   if (xfer && byte_idx == 2'd3) state_next = S_WR;
         S_WR:     state_next = (remaining == 16'd1) ? S_FIN : S_DATA;
         S_FIN:    state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_ready <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         cpu_hold   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cnt_lo     <= '0;
         remaining  <= '0;
         addr       <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
      end else begin
         byte_ready <= (state_next == S_HDR_LO) || (state_next == S_HDR_HI) ||
                       (state_next == S_DATA);
         busy       <= (state_next != S_IDLE);
         im_we      <= (state_next == S_WR);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            S_HDR_LO: if (xfer) cnt_lo <= byte_data;
            S_HDR_HI: begin
               if (xfer) begin
                  remaining <= hdr_n;
                  byte_idx  <= '0;
                  addr      <= '0;
                  if (hdr_n == 16'd0) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (n_too_big) begin
                     err <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_word[7:0]   <= byte_data;
                     2'd1: asm_word[15:8]  <= byte_data;
                     2'd2: asm_word[23:16] <= byte_data;
                     default: begin
                        // Top lane goes straight into the write word.
                        im_addr  <= addr;
                        im_wdata <= {byte_data, asm_word};
                     end
                  endcase
               end
            end
            S_WR: begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
